// File: rtl/alarm_trigger.sv
// alarm_trigger
// Compares the running time against the programmed alarm time and owns the
// ring / snooze / dismiss policy, presenting a clean active-high alarm level
// to the downstream buzzer/LED toggle stage.
//
// Optional feature macro: ALARM_SNOOZE_EN
//   defined   : SNOOZE state, snooze timer and per-event snooze count present.
//   undefined : no snooze; i_Snooze ignored; o_Snoozing and o_Snooze_Cnt tied 0.
module alarm_trigger #(
    parameter int unsigned RING_TIMEOUT_S = 60,
    parameter int unsigned SNOOZE_S       = 300,
    parameter int unsigned MAX_SNOOZES    = 3
) (
    input  logic                               i_Clk,
    input  logic                               i_Rst,
    input  logic                               i_Sec_Tick,
    input  logic [4:0]                         i_Hours,
    input  logic [5:0]                         i_Minutes,
    input  logic [4:0]                         i_Alarm_Hours,
    input  logic [5:0]                         i_Alarm_Minutes,
    input  logic                               i_Alarm_En,
    input  logic                               i_Snooze,
    input  logic                               i_Dismiss,
    output logic                               o_Alarm_On,
    output logic                               o_Snoozing,
    output logic [$clog2(MAX_SNOOZES+1)-1:0]   o_Snooze_Cnt
);

    localparam int unsigned RING_W = $clog2(RING_TIMEOUT_S + 1);
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TIMEOUT_S - 1);
    localparam logic [RING_W-1:0] RING_MAX  = RING_W'(RING_TIMEOUT_S);

`ifdef ALARM_SNOOZE_EN
    localparam int unsigned SNZ_W = $clog2(SNOOZE_S + 1);
    localparam int unsigned CNT_W = $clog2(MAX_SNOOZES + 1);
    localparam logic [SNZ_W-1:0] SNZ_LAST  = SNZ_W'(SNOOZE_S - 1);
    localparam logic [SNZ_W-1:0] SNZ_MAX   = SNZ_W'(SNOOZE_S);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_SNOOZES);

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZE   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2
    } state_t;
`endif

    state_t              state;
    state_t              state_next;

    logic                match;
    logic                r_Match_Q;
    logic                trigger;

    logic [RING_W-1:0]   ring_cnt;
    logic                ring_done;

`ifdef ALARM_SNOOZE_EN
    logic [SNZ_W-1:0]    snz_cnt;
    logic                snz_done;
    logic [CNT_W-1:0]    snooze_cnt;
`else
    logic                unused_ok;
    assign unused_ok = &{1'b0, i_Snooze, 32'(SNOOZE_S)};
`endif

    // Pure equality; an out-of-range alarm time simply never matches.
    assign match   = (i_Hours == i_Alarm_Hours) && (i_Minutes == i_Alarm_Minutes);
    assign trigger = match && !r_Match_Q;

    // Match history; reset to 1 so a match already present at reset release
    // does not count as a rising edge.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Match_Q <= 1'b1;
        end else begin
            r_Match_Q <= match;
        end
    end

    // The counters are only advanced while in their own state, so the tick that
    // coincides with the entry edge is never counted and a tick in the last
    // counted second ends the interval on that same edge.
    assign ring_done = i_Sec_Tick && (ring_cnt == RING_LAST);
`ifdef ALARM_SNOOZE_EN
    assign snz_done  = i_Sec_Tick && (snz_cnt == SNZ_LAST);
`endif

    // State register.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state <= DISARMED;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: disable overrides everything; in RINGING dismiss beats
    // snooze, which beats timeout.
    always_comb begin
        state_next = state;
        if (!i_Alarm_En) begin
            state_next = DISARMED;
        end else begin
            case (state)
                DISARMED: begin
                    state_next = ARMED;
                end
                ARMED: begin
                    if (trigger) begin
                        state_next = RINGING;
                    end
                end
                RINGING: begin
                    if (i_Dismiss) begin
                        state_next = ARMED;
`ifdef ALARM_SNOOZE_EN
                    end else if (i_Snooze && (snooze_cnt < CNT_LIMIT)) begin
                        state_next = SNOOZE;
`endif
                    end else if (ring_done) begin
                        state_next = ARMED;
                    end
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZE: begin
                    if (i_Dismiss) begin
                        state_next = ARMED;
                    end else if (snz_done) begin
                        state_next = RINGING;
                    end
                end
`endif
                default: begin
                    state_next = DISARMED;
                end
            endcase
        end
    end

    // Ring timer: held at zero outside RINGING, saturating inside it.
    always_ff @(posedge i_Clk) begin
        if (i_Rst || (state != RINGING)) begin
            ring_cnt <= '0;
        end else if (i_Sec_Tick && (ring_cnt != RING_MAX)) begin
            ring_cnt <= ring_cnt + 1'b1;
        end
    end

`ifdef ALARM_SNOOZE_EN
    // Snooze timer: held at zero outside SNOOZE, saturating inside it.
    always_ff @(posedge i_Clk) begin
        if (i_Rst || (state != SNOOZE)) begin
            snz_cnt <= '0;
        end else if (i_Sec_Tick && (snz_cnt != SNZ_MAX)) begin
            snz_cnt <= snz_cnt + 1'b1;
        end
    end

    // Snooze count: cleared whenever heading to ARMED/DISARMED, which also
    // covers the zeroing at the start of each new alarm event.
    always_ff @(posedge i_Clk) begin
        if (i_Rst || (state_next == ARMED) || (state_next == DISARMED)) begin
            snooze_cnt <= '0;
        end else if ((state == RINGING) && (state_next == SNOOZE)
                     && (snooze_cnt != CNT_LIMIT)) begin
            snooze_cnt <= snooze_cnt + 1'b1;
        end
    end
`endif

    // Output decode from the state register.
    always_comb begin
        o_Alarm_On   = (state == RINGING);
        o_Snoozing   = 1'b0;
        o_Snooze_Cnt = '0;
`ifdef ALARM_SNOOZE_EN
        o_Snoozing   = (state == SNOOZE);
        o_Snooze_Cnt = snooze_cnt;
`endif
    end

endmodule

// File: tb/tb_alarm_trigger.sv
// Testbench for alarm_trigger: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_alarm_trigger;

    localparam int unsigned RING_TIMEOUT_S = 60;
    localparam int unsigned SNOOZE_S       = 300;
    localparam int unsigned MAX_SNOOZES    = 3;
    localparam int unsigned CNT_W          = $clog2(MAX_SNOOZES + 1);
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ_ON = 1'b1;
`else
    localparam bit SNZ_ON = 1'b0;
`endif

    logic             i_Clk = 1'b0;
    logic             i_Rst;
    logic             i_Sec_Tick;
    logic [4:0]       i_Hours;
    logic [5:0]       i_Minutes;
    logic [4:0]       i_Alarm_Hours;
    logic [5:0]       i_Alarm_Minutes;
    logic             i_Alarm_En;
    logic             i_Snooze;
    logic             i_Dismiss;
    logic             o_Alarm_On;
    logic             o_Snoozing;
    logic [CNT_W-1:0] o_Snooze_Cnt;

    alarm_trigger #(
        .RING_TIMEOUT_S (RING_TIMEOUT_S),
        .SNOOZE_S       (SNOOZE_S),
        .MAX_SNOOZES    (MAX_SNOOZES)
    ) dut (
        .i_Clk           (i_Clk),
        .i_Rst           (i_Rst),
        .i_Sec_Tick      (i_Sec_Tick),
        .i_Hours         (i_Hours),
        .i_Minutes       (i_Minutes),
        .i_Alarm_Hours   (i_Alarm_Hours),
        .i_Alarm_Minutes (i_Alarm_Minutes),
        .i_Alarm_En      (i_Alarm_En),
        .i_Snooze        (i_Snooze),
        .i_Dismiss       (i_Dismiss),
        .o_Alarm_On      (o_Alarm_On),
        .o_Snoozing      (o_Snoozing),
        .o_Snooze_Cnt    (o_Snooze_Cnt)
    );

    always #5 i_Clk = ~i_Clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_OFF, M_WAIT, M_RING, M_NAP} mode_t;
    typedef struct {
        mode_t mode;
        bit    prev_eq;
        int    ring_secs;
        int    nap_secs;
        int    naps;
    } mdl_t;

    function automatic mdl_t model_step(input mdl_t s, input bit rst, input bit en,
                                        input bit tick, input bit snz, input bit dis,
                                        input bit eq);
        mdl_t n;
        bit   rise;
        n    = s;
        rise = eq && !s.prev_eq;
        if (rst) begin
            n.mode = M_OFF; n.prev_eq = 1'b1;
            n.ring_secs = 0; n.nap_secs = 0; n.naps = 0;
            return n;
        end
        n.prev_eq = eq;
        if (!en) begin
            n.mode = M_OFF;
            n.naps = 0;
            return n;
        end
        case (s.mode)
            M_OFF:  n.mode = M_WAIT;
            M_WAIT: if (rise) begin
                        n.mode = M_RING; n.ring_secs = 0; n.naps = 0;
                    end
            M_RING: begin
                if (dis) begin
                    n.mode = M_WAIT; n.naps = 0;
                end else if (SNZ_ON && snz && s.naps < int'(MAX_SNOOZES)) begin
                    n.mode = M_NAP; n.naps = s.naps + 1; n.nap_secs = 0;
                end else if (tick) begin
                    n.ring_secs = s.ring_secs + 1;
                    if (n.ring_secs >= int'(RING_TIMEOUT_S)) begin
                        n.mode = M_WAIT; n.naps = 0;
                    end
                end
            end
            M_NAP: begin
                if (dis) begin
                    n.mode = M_WAIT; n.naps = 0;
                end else if (tick) begin
                    n.nap_secs = s.nap_secs + 1;
                    if (n.nap_secs >= int'(SNOOZE_S)) begin
                        n.mode = M_RING; n.ring_secs = 0;
                    end
                end
            end
            default: n.mode = M_OFF;
        endcase
        return n;
    endfunction

    mdl_t m = '{mode: M_OFF, prev_eq: 1'b1, ring_secs: 0, nap_secs: 0, naps: 0};
    bit   m_started = 1'b0;

    // Model advance on the same edge the DUT samples its inputs.
    always @(posedge i_Clk) begin
        m <= model_step(m, i_Rst, i_Alarm_En, i_Sec_Tick, i_Snooze, i_Dismiss,
                        (i_Hours == i_Alarm_Hours) && (i_Minutes == i_Alarm_Minutes));
        m_started <= 1'b1;
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge i_Clk) begin
        if (m_started) begin
            check("model_alarm_on", int'(o_Alarm_On),   int'(m.mode == M_RING));
            check("model_snoozing", int'(o_Snoozing),   int'(m.mode == M_NAP));
            check("model_snz_cnt",  int'(o_Snooze_Cnt), m.naps);
        end
    end

    // ---------------- stimulus ----------------
    task automatic clk1();
        @(posedge i_Clk);
        #1;
        i_Sec_Tick = 1'b0;
        i_Snooze   = 1'b0;
        i_Dismiss  = 1'b0;
    endtask

    task automatic secs(input int n);
        repeat (n) begin
            i_Sec_Tick = 1'b1;
            clk1();
            clk1();
        end
    endtask

    task automatic set_time(input int h, input int mi);
        i_Hours   = 5'(h);
        i_Minutes = 6'(mi);
    endtask

    task automatic fire();
        set_time(7, 29);
        clk1();
        set_time(7, 30);
        clk1();
    endtask

    initial begin
        i_Rst = 1'b1; i_Alarm_En = 1'b0; i_Sec_Tick = 1'b0;
        i_Snooze = 1'b0; i_Dismiss = 1'b0;
        i_Alarm_Hours = 5'd7; i_Alarm_Minutes = 6'd30;
        set_time(7, 30);
        clk1();
        clk1();
        check("rst_alarm_on", int'(o_Alarm_On), 0);
        check("rst_snoozing", int'(o_Snoozing), 0);
        check("rst_snz_cnt",  int'(o_Snooze_Cnt), 0);

        // Release reset while time already equals alarm: must not ring.
        i_Rst = 1'b0; i_Alarm_En = 1'b1;
        repeat (4) clk1();
        check("no_trig_at_release", int'(o_Alarm_On), 0);

        // 07:29 -> 07:30 rings on the next cycle.
        fire();
        check("trig_latency", int'(o_Alarm_On), 1);
        i_Dismiss = 1'b1;
        clk1();
        check("dismiss_off", int'(o_Alarm_On), 0);
        repeat (5) clk1();
        check("hold_after_dismiss", int'(o_Alarm_On), 0);

        // Timeout; the tick on the triggering cycle is not counted.
        set_time(7, 29);
        clk1();
        set_time(7, 30);
        i_Sec_Tick = 1'b1;
        clk1();
        check("ring_entry", int'(o_Alarm_On), 1);
        secs(59);
        check("ring_before_timeout", int'(o_Alarm_On), 1);
        i_Sec_Tick = 1'b1;
        clk1();
        check("timeout_off", int'(o_Alarm_On), 0);

`ifdef ALARM_SNOOZE_EN
        fire();
        for (int k = 1; k <= 3; k++) begin
            i_Snooze = 1'b1;
            clk1();
            check("snooze_alarm_off", int'(o_Alarm_On), 0);
            check("snooze_flag", int'(o_Snoozing), 1);
            check("snooze_cnt", int'(o_Snooze_Cnt), k);
            secs(299);
            check("snooze_still", int'(o_Alarm_On), 0);
            i_Sec_Tick = 1'b1;
            clk1();
            check("snooze_resume", int'(o_Alarm_On), 1);
        end
        i_Snooze = 1'b1;
        clk1();
        check("snooze_limit_ring", int'(o_Alarm_On), 1);
        check("snooze_limit_flag", int'(o_Snoozing), 0);
        check("snooze_limit_cnt", int'(o_Snooze_Cnt), 3);
        i_Snooze = 1'b1;
        i_Dismiss = 1'b1;
        clk1();
        check("snz_dis_off", int'(o_Alarm_On), 0);
        check("snz_dis_cnt", int'(o_Snooze_Cnt), 0);
`else
        fire();
        i_Snooze = 1'b1;
        clk1();
        check("nosnz_ring", int'(o_Alarm_On), 1);
        check("nosnz_flag", int'(o_Snoozing), 0);
        i_Dismiss = 1'b1;
        clk1();
`endif

        // Disable while ringing clears all outputs next cycle.
        fire();
        i_Alarm_En = 1'b0;
        clk1();
        check("disable_on", int'(o_Alarm_On), 0);
        check("disable_snz", int'(o_Snoozing), 0);
        check("disable_cnt", int'(o_Snooze_Cnt), 0);
        i_Alarm_En = 1'b1;

        // Reset mid-ringing: silent and no re-trigger in the same minute.
        fire();
        i_Rst = 1'b1;
        clk1();
        i_Rst = 1'b0;
        check("rst_mid_ring", int'(o_Alarm_On), 0);
        repeat (5) clk1();
        check("no_retrigger", int'(o_Alarm_On), 0);

        // Randomized traffic.
        for (int c = 0; c < 20000; c++) begin
            i_Rst = ($urandom_range(0, 999) == 0);
            if (i_Alarm_En) i_Alarm_En = ($urandom_range(0, 499) != 0);
            else            i_Alarm_En = ($urandom_range(0, 19) == 0);
            i_Sec_Tick = 1'($urandom_range(0, 1));
            i_Snooze   = ($urandom_range(0, 59) == 0);
            i_Dismiss  = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 29) == 0) begin
                i_Minutes = 6'(28 + $urandom_range(0, 3));
                i_Hours   = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'd7;
            end
            if ($urandom_range(0, 2999) == 0)
                i_Alarm_Hours = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(24, 31)) : 5'd7;
            @(posedge i_Clk);
            #1;
        end
        i_Sec_Tick = 1'b0; i_Snooze = 1'b0; i_Dismiss = 1'b0; i_Rst = 1'b0;
        clk1();
        clk1();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
